rr_priority_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_priority_arbiter.sv | 92 +++++++++
 tb/tb_rr_priority_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the round-robin priority arbiter
package arb_pkg;

  // Widest request vector the one-hot helper can produce; callers size-cast down to N.
  localparam int ARB_MAX_N = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary index to one-hot; the caller keeps only its low N bits.
  function automatic logic [ARB_MAX_N-1:0] idx_to_onehot(input int unsigned idx);
    return {{(ARB_MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational first-set-bit search starting at a rotating pointer
module rr_pick #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic            hi_found;
  logic [IDXW-1:0] hi_idx;
  logic [IDXW-1:0] lo_idx;

  // Masked encoder covers bits at or above ptr; unmasked encoder supplies the wrap-around winner.
  always_comb begin
    found    = |req;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDXW'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDXW'(i);
        end
      end
    end
    idx = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - registered N-way arbiter with fixed or round-robin priority and valid/ready grant
module rr_priority_arbiter #(
  parameter int N       = 8,
  parameter int RR_MODE = 1,
  localparam int IDXW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot,
  input  logic            gnt_ready,
  output logic            any_req
);

  import arb_pkg::*;

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            valid_d;
  logic [IDXW-1:0] idx_d;
  logic [N-1:0]    onehot_d;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;

  assign any_req = |req;

  // In fixed mode ptr never leaves 0, so the same picker yields plain LSB-first priority.
  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, pointer and grant registers; reset drops any outstanding grant at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_valid  <= valid_d;
      gnt_idx    <= idx_d;
      gnt_onehot <= onehot_d;
    end
  end

  // Next state: arbitrate only from IDLE, hold the grant until accepted, then clear for one bubble.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = gnt_valid;
    idx_d    = gnt_idx;
    onehot_d = gnt_onehot;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = GRANT;
          valid_d  = 1'b1;
          idx_d    = pick_idx;
          onehot_d = N'(idx_to_onehot(32'(pick_idx)));
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          idx_d    = '0;
          onehot_d = '0;
          if (RR_MODE != 0) begin
            // Wrap against N-1 so non-power-of-two N never lets ptr reach N.
            ptr_d = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - scoreboard bench for round-robin, fixed and N=5 arbiter variants
module tb_rr_priority_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_v [3];
  logic       rdy_v [3];
  logic       val_v [3];
  logic       any_v [3];
  logic [2:0] idx_v [3];
  logic [7:0] oh_v  [3];
  logic [4:0] req5;
  logic [4:0] oh5;

  int checks;
  int errors;
  int exp_q[$];
  int mptr [3];

  assign req5    = req_v[2][4:0];
  assign oh_v[2] = {3'b000, oh5};

  rr_priority_arbiter #(.N(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_v[0]), .gnt_valid(val_v[0]), .gnt_idx(idx_v[0]),
    .gnt_onehot(oh_v[0]), .gnt_ready(rdy_v[0]), .any_req(any_v[0])
  );

  rr_priority_arbiter #(.N(8), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req(req_v[1]), .gnt_valid(val_v[1]), .gnt_idx(idx_v[1]),
    .gnt_onehot(oh_v[1]), .gnt_ready(rdy_v[1]), .any_req(any_v[1])
  );

  rr_priority_arbiter #(.N(5), .RR_MODE(1)) u_np5 (
    .clk(clk), .rst(rst), .req(req5), .gnt_valid(val_v[2]), .gnt_idx(idx_v[2]),
    .gnt_onehot(oh5), .gnt_ready(rdy_v[2]), .any_req(any_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nlines(input int d);
    return (d == 2) ? 5 : 8;
  endfunction

  // Reference winner: first set bit scanning up from p with wrap-around.
  function automatic int pick(input logic [7:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a grant is compared against the queue head at the cycle it is accepted.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (val_v[d] && rdy_v[d]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("d%0d_sb_unexpected", d), 1, 0);
          end else begin
            int e;
            e = exp_q.pop_front();
            check($sformatf("d%0d_sb_dut", d), d, e / 100);
            check($sformatf("d%0d_sb_idx", d), int'(idx_v[d]), e % 100);
            check($sformatf("d%0d_sb_onehot", d), int'(oh_v[d]), 1 << (e % 100));
          end
        end
      end
    end
  end

  // One request/grant/accept transaction; req is replaced by r_hold once the grant is up.
  task automatic grant(input int d, input logic [7:0] r, input int e, input int hold,
                       input logic [7:0] r_hold);
    req_v[d] = r;
    rdy_v[d] = 1'b0;
    exp_q.push_back(d * 100 + e);
    tick();
    check($sformatf("d%0d_any", d), int'(any_v[d]), int'(r != 0));
    check($sformatf("d%0d_latency_valid", d), int'(val_v[d]), 1);
    req_v[d] = r_hold;
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("d%0d_hold_valid", d), int'(val_v[d]), 1);
      check($sformatf("d%0d_hold_idx", d), int'(idx_v[d]), e);
      check($sformatf("d%0d_hold_any", d), int'(any_v[d]), int'(r_hold != 0));
    end
    rdy_v[d] = 1'b1;
    tick();
    check($sformatf("d%0d_bubble_valid", d), int'(val_v[d]), 0);
    check($sformatf("d%0d_bubble_onehot", d), int'(oh_v[d]), 0);
    rdy_v[d] = 1'b0;
    if (d != 1) mptr[d] = (e + 1) % nlines(d);
  endtask

  initial begin
    logic [7:0] r;
    int e;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_v[d] = '0;
      rdy_v[d] = 1'b0;
      mptr[d]  = 0;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_reset_valid", d), int'(val_v[d]), 0);
      check($sformatf("d%0d_reset_idx", d), int'(idx_v[d]), 0);
      check($sformatf("d%0d_reset_onehot", d), int'(oh_v[d]), 0);
    end
    rst = 1'b0;
    tick();

    // Round-robin stream with ready held high: 0, 2, 7, 0 with a bubble between each.
    req_v[0] = 8'b1000_0101;
    rdy_v[0] = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(7);
    exp_q.push_back(0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rr_stream_valid_%0d", k), int'(val_v[0]), k % 2);
    end
    req_v[0] = '0;
    rdy_v[0] = 1'b0;
    mptr[0]  = 1;
    tick();

    // Wrap from ptr 7 and hold the grant while req drops.
    grant(0, 8'b0100_0000, 6, 0, 8'h00);
    grant(0, 8'b0000_0011, 0, 5, 8'h00);

    // Reset in the middle of an outstanding grant, then confirm ptr returned to 0.
    grant(0, 8'b0000_0100, 2, 0, 8'h00);
    req_v[0] = 8'b1000_0001;
    tick();
    check("rst_pre_valid", int'(val_v[0]), 1);
    check("rst_pre_idx", int'(idx_v[0]), 7);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", int'(val_v[0]), 0);
    check("rst_async_idx", int'(idx_v[0]), 0);
    check("rst_async_onehot", int'(oh_v[0]), 0);
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) mptr[d] = 0;
    grant(0, 8'b1000_0001, 0, 0, 8'h00);

    // No requests with ready toggling: nothing happens and ptr stays put.
    req_v[0] = '0;
    for (int k = 0; k < 6; k++) begin
      rdy_v[0] = k[0];
      tick();
      check("empty_valid", int'(val_v[0]), 0);
      check("empty_any", int'(any_v[0]), 0);
    end
    rdy_v[0] = 1'b0;
    grant(0, 8'hFF, mptr[0], 0, 8'h00);

    for (int k = 0; k < 12; k++) begin
      r = 8'($urandom_range(1, 255));
      e = pick(r, mptr[0], 8);
      grant(0, r, e, k % 3, 8'h00);
    end

    // Fixed priority: bit 0 highest and repeated grants never rotate.
    grant(1, 8'b1010_0100, 2, 0, 8'b1010_0100);
    grant(1, 8'b1010_0100, 2, 0, 8'h00);
    grant(1, 8'b1000_0000, 7, 0, 8'h00);
    grant(1, 8'b1000_0001, 0, 2, 8'h00);
    for (int k = 0; k < 6; k++) begin
      r = 8'($urandom_range(1, 255));
      grant(1, r, pick(r, 0, 8), 0, 8'h00);
    end

    // N = 5: granting index 4 must wrap ptr to 0.
    grant(2, 8'b0001_0000, 4, 0, 8'h00);
    grant(2, 8'b0000_0001, 0, 0, 8'h00);
    grant(2, 8'b0001_0010, 1, 0, 8'h00);
    grant(2, 8'b0001_0001, 4, 0, 8'h00);
    grant(2, 8'b0000_0011, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      r = 8'($urandom_range(1, 31));
      e = pick(r, mptr[2], 5);
      grant(2, r, e, 0, 8'h00);
    end

    tick();
    check("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
